// File: rtl/sm_regdump_pkg.sv
// Shared definitions for the sm_regdump register-file dump engine:
// FSM state encodings and the tag-byte prefix used when SM_REGDUMP_TAG_EN is defined.
package sm_regdump_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_TAG  = 2'd2,
        S_SEND = 2'd3
    } state_t;

    localparam logic [2:0] REGDUMP_TAG = 3'b101;

    function automatic logic [7:0] tag_byte(input logic [4:0] index);
        return {REGDUMP_TAG, index};
    endfunction

endpackage

// File: rtl/sm_regdump_ser.sv
// Word-to-byte serializer for sm_regdump: holds one captured 32-bit word and
// streams it MSB first (optionally preceded by a tag byte) over valid/ready.
module sm_regdump_ser
    import sm_regdump_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_tag_phase,
    input  logic        i_send_phase,
    input  logic [4:0]  i_index,
    input  logic        i_out_ready,
    output logic [7:0]  o_out_data,
    output logic        o_out_valid,
    output logic        o_xfer,
    output logic        o_word_done
);

    logic [31:0] r_hold;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  w_data;
    logic        w_valid;
    logic        w_xfer;

    assign w_valid = i_tag_phase | i_send_phase;
    assign w_xfer  = w_valid & i_out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= '0;
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_hold     <= i_word;
            r_byte_cnt <= '0;
        end else if (i_send_phase && w_xfer) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

    // NOTE: w_data gets a default first so the mux can never infer a latch.
    always_comb begin
        w_data = 8'h00;
        if (i_tag_phase) begin
            w_data = tag_byte(i_index);
        end else if (i_send_phase) begin
            case (r_byte_cnt)
                2'd0:    w_data = r_hold[31:24];
                2'd1:    w_data = r_hold[23:16];
                2'd2:    w_data = r_hold[15:8];
                default: w_data = r_hold[7:0];
            endcase
        end
    end

    assign o_out_data  = w_data;
    assign o_out_valid = w_valid;
    assign o_xfer      = w_xfer;
    assign o_word_done = i_send_phase & w_xfer & (r_byte_cnt == 2'd3);

endmodule

// File: rtl/sm_regdump.sv
// Register-file dump engine for schoolMIPS: scans regAddr over REG_FIRST..REG_LAST
// and streams each word as bytes. Define SM_REGDUMP_TAG_EN to prefix each word with a tag byte.
module sm_regdump
    import sm_regdump_pkg::*;
#(
    parameter int REG_FIRST = 0,
    parameter int REG_LAST  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_IDX = 5'(REG_FIRST);
    localparam logic [4:0] LAST_IDX  = 5'(REG_LAST);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_index;
    logic       r_done;
    logic       w_xfer;
    logic       w_word_done;
    logic       w_last;

    assign w_last = (r_index == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_word_done & w_last;
            if (r_state == S_IDLE && start) begin
                r_index <= FIRST_IDX;
            end else if (w_word_done && !w_last) begin
                r_index <= r_index + 5'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_ADDR;
`ifdef SM_REGDUMP_TAG_EN
            S_ADDR: w_next = S_TAG;
`else
            S_ADDR: w_next = S_SEND;
`endif
            S_TAG:  if (w_xfer) w_next = S_SEND;
            S_SEND: if (w_word_done) w_next = w_last ? S_IDLE : S_ADDR;
            default: w_next = S_IDLE;
        endcase
    end

    sm_regdump_ser u_ser (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (r_state == S_ADDR),
        .i_word       (regData),
        .i_tag_phase  (r_state == S_TAG),
        .i_send_phase (r_state == S_SEND),
        .i_index      (r_index),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_valid  (out_valid),
        .o_xfer       (w_xfer),
        .o_word_done  (w_word_done)
    );

    assign regAddr = (r_state == S_IDLE) ? FIRST_IDX : r_index;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;

endmodule

// File: tb/tb_sm_regdump.sv
// Self-checking bench for sm_regdump: three instances with different register ranges,
// compared against a byte-stream model built from the register-file contents.
module tb_sm_regdump;

    localparam int N = 3;
`ifdef SM_REGDUMP_TAG_EN
    localparam int TAG_BYTES = 1;
`else
    localparam int TAG_BYTES = 0;
`endif

    int first_of[N] = '{0, 2, 3};
    int last_of[N]  = '{31, 2, 5};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start     [N];
    logic        out_ready [N];
    logic [4:0]  reg_addr  [N];
    logic [31:0] reg_data  [N];
    logic [7:0]  out_data  [N];
    logic        out_valid [N];
    logic        busy      [N];
    logic        done      [N];
    logic [31:0] rf        [32];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign reg_data[0] = rf[reg_addr[0]];
    assign reg_data[1] = rf[reg_addr[1]];
    assign reg_data[2] = rf[reg_addr[2]];

    sm_regdump #(.REG_FIRST(0), .REG_LAST(31)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .regAddr(reg_addr[0]), .regData(reg_data[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .busy(busy[0]), .done(done[0]));

    sm_regdump #(.REG_FIRST(2), .REG_LAST(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .regAddr(reg_addr[1]), .regData(reg_data[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .busy(busy[1]), .done(done[1]));

    sm_regdump #(.REG_FIRST(3), .REG_LAST(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .regAddr(reg_addr[2]), .regData(reg_data[2]),
        .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .busy(busy[2]), .done(done[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input int k);
        check("idle_valid", 32'(out_valid[k]), 32'd0);
        check("idle_busy", 32'(busy[k]), 32'd0);
        check("idle_addr", 32'(reg_addr[k]), 32'(first_of[k]));
        check("idle_done", 32'(done[k]), 32'd0);
    endtask

    // mode 0: ready high, 1: random ready, 2: three stall cycles on the second byte
    task automatic run_dump(input int k, input int mode, input bit poke_start);
        logic [7:0] exp_q[$];
        int nregs, bpw, total, cyc, rx, stalls, stall_left, word;
        bit got_done, prev_valid, prev_ready;
        logic [7:0] prev_data;

        for (int r = first_of[k]; r <= last_of[k]; r++) begin
            if (TAG_BYTES != 0) exp_q.push_back(8'(160 + r));
            for (int b = 3; b >= 0; b--) exp_q.push_back(8'((rf[r] >> (8 * b)) & 32'hFF));
        end
        nregs = last_of[k] - first_of[k] + 1;
        bpw   = 4 + TAG_BYTES;
        total = nregs * bpw;
        cyc = 0; rx = 0; stalls = 0; stall_left = 3; got_done = 0;
        prev_valid = 0; prev_ready = 0; prev_data = '0;

        @(negedge clk) start[k] = 1'b1;
        @(negedge clk) start[k] = 1'b0;
        while (!got_done && cyc < 4000) begin
            if (cyc > 0) @(negedge clk);
            case (mode)
                0: out_ready[k] = 1'b1;
                1: out_ready[k] = ($urandom_range(0, 99) < 65);
                default: begin
                    out_ready[k] = !(out_valid[k] && rx == 1 && stall_left > 0);
                    if (!out_ready[k]) stall_left--;
                end
            endcase
            if (poke_start && cyc == 3) start[k] = 1'b1;
            if (poke_start && cyc == 4) start[k] = 1'b0;
            if (cyc == 0) check("addr_valid", 32'(out_valid[k]), 32'd0);
            if (done[k]) begin
                got_done = 1;
                check("done_cycle", 32'(cyc), 32'(total + nregs + stalls));
                check("busy_at_done", 32'(busy[k]), 32'd0);
                check("bytes_at_done", 32'(rx), 32'(total));
            end else begin
                check("busy", 32'(busy[k]), 32'd1);
                word = rx / bpw;
                if (word < nregs) check("reg_addr", 32'(reg_addr[k]), 32'(first_of[k] + word));
                if (prev_valid && !prev_ready) begin
                    check("valid_hold", 32'(out_valid[k]), 32'd1);
                    check("data_hold", 32'(out_data[k]), 32'(prev_data));
                end
                if (out_valid[k] && out_ready[k]) begin
                    check("byte_in_range", 32'(rx < total), 32'd1);
                    if (rx < total) check("byte", 32'(out_data[k]), 32'(exp_q[rx]));
                    rx++;
                end else if (out_valid[k]) begin
                    stalls++;
                end
            end
            prev_valid = out_valid[k];
            prev_ready = out_ready[k];
            prev_data  = out_data[k];
            cyc++;
        end
        check("done_seen", 32'(got_done), 32'd1);
        if (mode == 2) check("stall_count", 32'(stalls), 32'd3);
        repeat (3) begin
            @(negedge clk);
            check_idle(k);
        end
    endtask

    task automatic mid_reset_test();
        @(negedge clk) start[0] = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_valid", 32'(out_valid[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_addr", 32'(reg_addr[0]), 32'(first_of[0]));
        check("rst_data", 32'(out_data[0]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", 32'(done[0]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle(0);
        end
    endtask

    task automatic retrigger_test();
        int c;
        @(negedge clk) start[1] = 1'b1;
        out_ready[1] = 1'b1;
        c = 0;
        while (!done[1] && c < 100) begin @(negedge clk); c++; end
        check("retrig_done1", 32'(done[1]), 32'd1);
        @(negedge clk);
        check("retrig_busy", 32'(busy[1]), 32'd1);
        start[1] = 1'b0;
        c = 0;
        while (!done[1] && c < 100) begin @(negedge clk); c++; end
        check("retrig_done2", 32'(done[1]), 32'd1);
        @(negedge clk);
        check_idle(1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            start[i]     = 1'b0;
            out_ready[i] = 1'b0;
        end
        rf[0] = 32'h0000_0040;
        for (int i = 1; i < 32; i++) rf[i] = 32'(i);
        rf[2] = 32'h1234_5678;

        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check_idle(i);
            check("rst_out_data", 32'(out_data[i]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_idle(0);
        end

        run_dump(1, 0, 0);
        run_dump(1, 2, 0);
        rf[2] = 32'd2;
        run_dump(0, 0, 0);
        run_dump(2, 0, 0);

        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_dump(0, 1, 1);
        run_dump(2, 1, 0);
        run_dump(1, 1, 1);

        mid_reset_test();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run_dump(0, 1, 0);
        retrigger_test();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
